// File: rtl/bus_arbit.sv
// Purpose : two-master bus arbiter with tie-break on last owner and a bounded burst tenure.
// Latency : grant registered, one cycle after the request is sampled; m_* muxing is combinational.
// Backpressure: a master holding the bus while the other requests is handed off after MAX_BURST cycles.
//
// Ports:
//   clk, reset                     - sole clock; synchronous active-high reset
//   m0_req/m0_wr/m0_address/m0_dout - master 0 request, write enable, address, write data
//   m1_req/m1_wr/m1_address/m1_dout - master 1 equivalents
//   m0_grant, m1_grant             - registered bus ownership, never both high
//   m_req/m_wr/m_address/m_dout    - granted master's signals, all zero when nobody owns the bus
module bus_arbit #(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [15:0] m0_address,
    input  logic [31:0] m0_dout,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [15:0] m1_address,
    input  logic [31:0] m1_dout,
    output logic        m0_grant,
    output logic        m1_grant,
    output logic        m_req,
    output logic        m_wr,
    output logic [15:0] m_address,
    output logic [31:0] m_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    // Tenure value at which a contended owner must yield (cnt counts from 0).
    localparam logic [7:0] LP_LAST_BEAT = 8'(MAX_BURST - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic        r_last;
    logic        w_last_nxt;
    logic        r_m0_grant;
    logic        r_m1_grant;
    logic        w_burst_done;

    assign w_burst_done = (r_cnt == LP_LAST_BEAT);

    // Next-state logic. Hand-overs go straight between GRANT states so the
    // bus never idles for a cycle while the other master is waiting.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    // Tie: favour whichever master did not own the bus last.
                    w_next = r_last ? GRANT0 : GRANT1;
                end else if (m0_req) begin
                    w_next = GRANT0;
                end else if (m1_req) begin
                    w_next = GRANT1;
                end
            end
            GRANT0: begin
                if (!m0_req) begin
                    w_next = m1_req ? GRANT1 : IDLE;
                end else if (m1_req && w_burst_done) begin
                    w_next = GRANT1;
                end
            end
            GRANT1: begin
                if (!m1_req) begin
                    w_next = m0_req ? GRANT0 : IDLE;
                end else if (m0_req && w_burst_done) begin
                    w_next = GRANT0;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Tenure counter restarts on any state change and saturates while held.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_next != r_state) begin
            w_cnt_nxt = 8'd0;
        end else if (r_cnt != 8'hFF) begin
            w_cnt_nxt = r_cnt + 8'd1;
        end
    end

    always_comb begin
        w_last_nxt = r_last;
        if (w_next == GRANT0 && r_state != GRANT0) begin
            w_last_nxt = 1'b0;
        end else if (w_next == GRANT1 && r_state != GRANT1) begin
            w_last_nxt = 1'b1;
        end
    end

    // Grants get their own flops so the outputs come straight from registers
    // rather than through a state decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= 8'd0;
            r_last     <= 1'b1;
            r_m0_grant <= 1'b0;
            r_m1_grant <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt_nxt;
            r_last     <= w_last_nxt;
            r_m0_grant <= (w_next == GRANT0);
            r_m1_grant <= (w_next == GRANT1);
        end
    end

    assign m0_grant = r_m0_grant;
    assign m1_grant = r_m1_grant;

    // Downstream mux: only the owner's inputs pass; everything is zero when idle.
    always_comb begin
        m_req     = 1'b0;
        m_wr      = 1'b0;
        m_address = 16'h0000;
        m_dout    = 32'h0000_0000;
        if (r_m0_grant) begin
            m_req     = m0_req;
            m_wr      = m0_wr;
            m_address = m0_address;
            m_dout    = m0_dout;
        end else if (r_m1_grant) begin
            m_req     = m1_req;
            m_wr      = m1_wr;
            m_address = m1_address;
            m_dout    = m1_dout;
        end
    end

endmodule

// File: doc/bus_arbit.md
BUS_ARBIT -- requirements
Module: bus_arbit

Interface
REQ-001 Parameter MAX_BURST, default 8, consecutive grant cycles a master keeps while the other master is requesting; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 m0_req  input  1  master 0 bus request.
REQ-005 m0_wr  input  1  master 0 write enable (1 = write).
REQ-006 m0_address  input  16  master 0 address.
REQ-007 m0_dout  input  32  master 0 write data.
REQ-008 m1_req, m1_wr, m1_address, m1_dout  input  1/1/16/32  master 1 equivalents of REQ-004..REQ-007.
REQ-009 m0_grant  output  1  registered; master 0 owns the bus.
REQ-010 m1_grant  output  1  registered; master 1 owns the bus.
REQ-011 m_req  output  1  muxed request to the downstream address decoder.
REQ-012 m_wr  output  1  muxed write enable.
REQ-013 m_address  output  16  muxed address, feeds the address decoder.
REQ-014 m_dout  output  32  muxed write data.

Function
REQ-015 State machine SHALL have exactly three states: IDLE, GRANT0, GRANT1; m0_grant=1 only in GRANT0, m1_grant=1 only in GRANT1, never both.
REQ-016 An 8-bit tenure counter cnt SHALL count cycles spent in the current GRANT state; it clears to 0 on every state change and increments, saturating at 255, while the state is held.
REQ-017 A 1-bit register last SHALL record the most recently granted master, updated on entry to GRANT0 (last=0) or GRANT1 (last=1).
REQ-018 IDLE: only m0_req -> GRANT0; only m1_req -> GRANT1; both -> the master not equal to last; neither -> IDLE.
REQ-019 GRANT0: m0_req=0 and m1_req=1 -> GRANT1; m0_req=0 and m1_req=0 -> IDLE.
REQ-020 GRANT0: m0_req=1, m1_req=1 and cnt=MAX_BURST-1 -> GRANT1 (forced hand-over); otherwise stay.
REQ-021 GRANT1 SHALL mirror REQ-019/REQ-020 with master indices swapped.
REQ-022 Grant latency SHALL be exactly one cycle: a request sampled on edge N yields the grant after edge N; release takes effect after the edge on which req is sampled 0.
REQ-023 m_req, m_wr, m_address and m_dout SHALL be combinational selections of the granted master's inputs, with m_req = granted master's req AND its grant.
REQ-024 With no grant (IDLE) m_req, m_wr, m_address and m_dout SHALL all be 0.
REQ-025 A hand-over SHALL never leave a gap cycle: GRANT0->GRANT1 and GRANT1->GRANT0 are direct transitions, not through IDLE.
REQ-026 A non-granted master's input changes SHALL have no effect on the m_* outputs.

Reset
REQ-027 When reset is sampled 1: state=IDLE, cnt=0, last=1 (master 0 wins the first tie), m0_grant=0, m1_grant=0.
REQ-028 Reset SHALL override all transitions, including mid-grant and mid-forced-hand-over; outputs reach reset values after that edge.
REQ-029 After reset deasserts, a request sampled on the first edge SHALL be granted per REQ-018.

Verification
REQ-030 Reset, then m0_req=1 and m1_req=1 from the same edge -> m0_grant=1 one cycle later, m1_grant=0.
REQ-031 m0 alone with m0_address=16'h0712, m0_wr=1, m0_dout=32'hDEADBEEF -> m_req=1, m_address=16'h0712, m_wr=1, m_dout=32'hDEADBEEF while m0_grant=1; m1 input changes leave outputs unchanged.
REQ-032 Both request continuously with MAX_BURST=8 -> grant alternates every 8 cycles (8 cycles m0_grant, 8 cycles m1_grant, ...) with no idle cycle.
REQ-033 GRANT1 held, m1_req drops with m0_req=0 -> IDLE next cycle with all m_* = 0; then m0_req=1 -> GRANT0 the following cycle.
REQ-034 Reset asserted during GRANT1 at cnt=5 -> next cycle both grants 0, m_address=16'h0000; a later simultaneous request -> master 0 granted.
